// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and engine state types for the line-based AXI4 master.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_BRESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RET} r_state_t;

  // Beat offset counter width; a single-beat line still needs one bit.
  function automatic int offset_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_serdes.sv
// Line buffer with beat offset counter: serializes a loaded line into beats
// or deserializes captured beats into a line.
module line_serdes #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 32,
  parameter int OFF_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LINE_W-1:0] line_in,
  input  logic              capture,
  input  logic [BEAT_W-1:0] beat_in,
  input  logic              advance,
  output logic              last,
  output logic [BEAT_W-1:0] beat_out,
  output logic [LINE_W-1:0] line_out
);

  localparam int N = LINE_W / BEAT_W;

  logic [OFF_W-1:0]  off_reg;
  logic [BEAT_W-1:0] beats [N];

  assign last     = (off_reg == OFF_W'(N - 1));
  assign beat_out = beats[off_reg];

  // Loading a new line always restarts the burst at beat 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_reg <= '0;
    end else if (load) begin
      off_reg <= '0;
    end else if (advance) begin
      off_reg <= last ? '0 : off_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_beat
      logic [BEAT_W-1:0] beat_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          beat_reg <= '0;
        end else if (load) begin
          beat_reg <= line_in[gi*BEAT_W +: BEAT_W];
        end else if (capture && (off_reg == OFF_W'(gi))) begin
          beat_reg <= beat_in;
        end
      end

      assign beats[gi]                       = beat_reg;
      assign line_out[gi*BEAT_W +: BEAT_W]   = beat_reg;
    end
  endgenerate

endmodule

// File: rtl/axi4_master.sv
// Native line read/write to AXI4 INCR burst bridge with independent read and
// write engines and a same-address hazard interlock between them.
module axi4_master
  import axi_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int AXI_DW    = 32,
  parameter int RESP_W    = 2,
  parameter int NATIVE_DW = 256,
  parameter int MASTER_ID = 0
) (
  input  logic                 aclk_i,
  input  logic                 aresetn_i,

  input  logic                 nat_write_valid_i,
  output logic                 nat_write_ready_o,
  input  logic [ADDR_W-1:0]    nat_write_addr_i,
  input  logic [NATIVE_DW-1:0] nat_write_data_i,
  output logic                 nat_write_done_o,
  output logic                 nat_write_err_o,

  input  logic                 nat_read_valid_i,
  output logic                 nat_read_ready_o,
  input  logic [ADDR_W-1:0]    nat_read_addr_i,
  output logic                 nat_read_valid_o,
  output logic [ADDR_W-1:0]    nat_read_addr_o,
  output logic [NATIVE_DW-1:0] nat_read_data_o,
  output logic                 nat_read_err_o,

  output logic                 m_axi_awvalid_o,
  input  logic                 m_axi_awready_i,
  output logic [ADDR_W-1:0]    m_axi_awaddr_o,
  output logic [1:0]           m_axi_awburst_o,
  output logic [7:0]           m_axi_awlen_o,
  output logic [2:0]           m_axi_awsize_o,
  output logic [ID_W-1:0]      m_axi_awid_o,

  output logic                 m_axi_wvalid_o,
  input  logic                 m_axi_wready_i,
  output logic                 m_axi_wlast_o,
  output logic [AXI_DW-1:0]    m_axi_wdata_o,
  output logic [AXI_DW/8-1:0]  m_axi_wstrb_o,

  input  logic                 m_axi_bvalid_i,
  output logic                 m_axi_bready_o,
  input  logic [ID_W-1:0]      m_axi_bid_i,
  input  logic [RESP_W-1:0]    m_axi_bresp_i,

  output logic                 m_axi_arvalid_o,
  input  logic                 m_axi_arready_i,
  output logic [ADDR_W-1:0]    m_axi_araddr_o,
  output logic [1:0]           m_axi_arburst_o,
  output logic [7:0]           m_axi_arlen_o,
  output logic [2:0]           m_axi_arsize_o,
  output logic [ID_W-1:0]      m_axi_arid_o,

  input  logic                 m_axi_rvalid_i,
  output logic                 m_axi_rready_o,
  input  logic [AXI_DW-1:0]    m_axi_rdata_i,
  input  logic                 m_axi_rlast_i,
  input  logic [ID_W-1:0]      m_axi_rid_i,
  input  logic [RESP_W-1:0]    m_axi_rresp_i
);

  localparam int NBYTES   = AXI_DW / 8;
  localparam int NTRANSF  = NATIVE_DW / AXI_DW;
  localparam int OFFSET_W = offset_width(NTRANSF);
  localparam int SIZE     = $clog2(NBYTES);

  localparam logic [ID_W-1:0]   ID_VAL  = ID_W'(MASTER_ID);
  localparam logic [RESP_W-1:0] OKAY_RV = RESP_W'(RESP_OKAY);

  w_state_t            w_state_reg;
  r_state_t            r_state_reg;
  logic [ADDR_W-1:0]   w_addr_reg;
  logic [ADDR_W-1:0]   r_addr_reg;
  logic                w_done_reg;
  logic                w_err_reg;
  logic                r_valid_reg;
  logic                r_err_reg;
  logic                armed_reg;

  logic                w_busy;
  logic                r_busy;
  logic                w_accept;
  logic                r_accept;
  logic                w_beat_fire;
  logic                r_beat_fire;
  logic                w_last;
  logic                r_last;
  logic                r_beat_bad;
  logic [AXI_DW-1:0]   w_beat;
  logic [NATIVE_DW-1:0] r_line;
  logic [NATIVE_DW-1:0] w_line_unused;
  logic [AXI_DW-1:0]   r_beat_unused;

  assign w_busy = (w_state_reg != W_IDLE);
  assign r_busy = (r_state_reg != R_IDLE);

  // Ready stays low during and immediately after reset until the first clock.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      armed_reg <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
    end
  end

  // A same-address collision between two idle engines is resolved in favour of the write.
  assign nat_write_ready_o = armed_reg && !w_busy &&
                             !(r_busy && (r_addr_reg == nat_write_addr_i));
  assign nat_read_ready_o  = armed_reg && !r_busy &&
                             !(w_busy && (w_addr_reg == nat_read_addr_i)) &&
                             !(nat_write_valid_i && nat_write_ready_o &&
                               (nat_write_addr_i == nat_read_addr_i));

  assign w_accept    = nat_write_valid_i && nat_write_ready_o;
  assign r_accept    = nat_read_valid_i && nat_read_ready_o;
  assign w_beat_fire = (w_state_reg == W_DATA) && m_axi_wready_i;
  assign r_beat_fire = (r_state_reg == R_DATA) && m_axi_rvalid_i;
  assign r_beat_bad  = (m_axi_rresp_i != OKAY_RV) || (m_axi_rid_i != ID_VAL);

  line_serdes #(
    .LINE_W (NATIVE_DW),
    .BEAT_W (AXI_DW),
    .OFF_W  (OFFSET_W)
  ) u_wr_ser (
    .clk      (aclk_i),
    .rst_n    (aresetn_i),
    .load     (w_accept),
    .line_in  (nat_write_data_i),
    .capture  (1'b0),
    .beat_in  ('0),
    .advance  (w_beat_fire),
    .last     (w_last),
    .beat_out (w_beat),
    .line_out (w_line_unused)
  );

  line_serdes #(
    .LINE_W (NATIVE_DW),
    .BEAT_W (AXI_DW),
    .OFF_W  (OFFSET_W)
  ) u_rd_des (
    .clk      (aclk_i),
    .rst_n    (aresetn_i),
    .load     (r_accept),
    .line_in  ('0),
    .capture  (r_beat_fire),
    .beat_in  (m_axi_rdata_i),
    .advance  (r_beat_fire),
    .last     (r_last),
    .beat_out (r_beat_unused),
    .line_out (r_line)
  );

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      w_state_reg <= W_IDLE;
      w_addr_reg  <= '0;
      w_done_reg  <= 1'b0;
      w_err_reg   <= 1'b0;
    end else begin
      w_done_reg <= 1'b0;
      w_err_reg  <= 1'b0;
      case (w_state_reg)
        W_IDLE: begin
          if (w_accept) begin
            w_addr_reg  <= nat_write_addr_i;
            w_state_reg <= W_AW;
          end
        end
        W_AW: begin
          if (m_axi_awready_i) w_state_reg <= W_DATA;
        end
        W_DATA: begin
          if (m_axi_wready_i && w_last) w_state_reg <= W_BRESP;
        end
        W_BRESP: begin
          if (m_axi_bvalid_i) begin
            w_done_reg  <= 1'b1;
            w_err_reg   <= (m_axi_bresp_i != OKAY_RV) || (m_axi_bid_i != ID_VAL);
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // A beat whose rlast disagrees with the expected last offset ends the burst with error.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state_reg <= R_IDLE;
      r_addr_reg  <= '0;
      r_valid_reg <= 1'b0;
      r_err_reg   <= 1'b0;
    end else begin
      r_valid_reg <= 1'b0;
      case (r_state_reg)
        R_IDLE: begin
          if (r_accept) begin
            r_addr_reg  <= nat_read_addr_i;
            r_err_reg   <= 1'b0;
            r_state_reg <= R_AR;
          end
        end
        R_AR: begin
          if (m_axi_arready_i) r_state_reg <= R_DATA;
        end
        R_DATA: begin
          if (m_axi_rvalid_i) begin
            if (r_beat_bad || (m_axi_rlast_i != r_last)) r_err_reg <= 1'b1;
            if (m_axi_rlast_i || r_last) r_state_reg <= R_RET;
          end
        end
        R_RET: begin
          r_valid_reg <= 1'b1;
          r_state_reg <= R_IDLE;
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  assign nat_write_done_o = w_done_reg;
  assign nat_write_err_o  = w_err_reg;
  assign nat_read_valid_o = r_valid_reg;
  assign nat_read_addr_o  = r_addr_reg;
  assign nat_read_data_o  = r_line;
  assign nat_read_err_o   = r_err_reg;

  assign m_axi_awvalid_o = (w_state_reg == W_AW);
  assign m_axi_awaddr_o  = w_addr_reg;
  assign m_axi_awburst_o = BURST_INCR;
  assign m_axi_awlen_o   = 8'(NTRANSF - 1);
  assign m_axi_awsize_o  = 3'(SIZE);
  assign m_axi_awid_o    = ID_VAL;

  assign m_axi_wvalid_o  = (w_state_reg == W_DATA);
  assign m_axi_wlast_o   = (w_state_reg == W_DATA) && w_last;
  assign m_axi_wdata_o   = w_beat;
  assign m_axi_wstrb_o   = '1;
  assign m_axi_bready_o  = (w_state_reg == W_BRESP);

  assign m_axi_arvalid_o = (r_state_reg == R_AR);
  assign m_axi_araddr_o  = r_addr_reg;
  assign m_axi_arburst_o = BURST_INCR;
  assign m_axi_arlen_o   = 8'(NTRANSF - 1);
  assign m_axi_arsize_o  = 3'(SIZE);
  assign m_axi_arid_o    = ID_VAL;
  assign m_axi_rready_o  = (r_state_reg == R_DATA);

endmodule

// File: tb/tb_axi4_master.sv
// Scoreboard bench for axi4_master: stimulus pushes expectations, a monitor pops and compares.
module tb_axi4_master;
  localparam int ID_W = 4, ADDR_W = 32, AXI_DW = 32, RESP_W = 2, NATIVE_DW = 256, NT = 8;

  logic aclk, aresetn;
  logic nat_write_valid_i, nat_write_ready_o, nat_write_done_o, nat_write_err_o;
  logic [ADDR_W-1:0] nat_write_addr_i, nat_read_addr_i, nat_read_addr_o;
  logic [NATIVE_DW-1:0] nat_write_data_i, nat_read_data_o;
  logic nat_read_valid_i, nat_read_ready_o, nat_read_valid_o, nat_read_err_o;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready, arvalid, arready;
  logic rvalid, rready, rlast;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [1:0] awburst, arburst;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [ID_W-1:0] awid, arid, bid, rid;
  logic [AXI_DW-1:0] wdata, rdata;
  logic [AXI_DW/8-1:0] wstrb;
  logic [RESP_W-1:0] bresp, rresp;

  axi4_master dut (
    .aclk_i(aclk), .aresetn_i(aresetn),
    .nat_write_valid_i(nat_write_valid_i), .nat_write_ready_o(nat_write_ready_o),
    .nat_write_addr_i(nat_write_addr_i), .nat_write_data_i(nat_write_data_i),
    .nat_write_done_o(nat_write_done_o), .nat_write_err_o(nat_write_err_o),
    .nat_read_valid_i(nat_read_valid_i), .nat_read_ready_o(nat_read_ready_o),
    .nat_read_addr_i(nat_read_addr_i), .nat_read_valid_o(nat_read_valid_o),
    .nat_read_addr_o(nat_read_addr_o), .nat_read_data_o(nat_read_data_o),
    .nat_read_err_o(nat_read_err_o),
    .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready), .m_axi_awaddr_o(awaddr),
    .m_axi_awburst_o(awburst), .m_axi_awlen_o(awlen), .m_axi_awsize_o(awsize),
    .m_axi_awid_o(awid),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready), .m_axi_wlast_o(wlast),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb),
    .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready), .m_axi_bid_i(bid),
    .m_axi_bresp_i(bresp),
    .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready), .m_axi_araddr_o(araddr),
    .m_axi_arburst_o(arburst), .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize),
    .m_axi_arid_o(arid),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready), .m_axi_rdata_i(rdata),
    .m_axi_rlast_i(rlast), .m_axi_rid_i(rid), .m_axi_rresp_i(rresp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct { logic err; int due; } wdone_t;
  typedef struct {
    logic [ADDR_W-1:0] addr; logic [NATIVE_DW-1:0] data; logic [NATIVE_DW-1:0] mask;
    logic err; int due;
  } rret_t;

  logic [ADDR_W-1:0] exp_aw_q[$], exp_ar_q[$];
  logic [AXI_DW:0]   exp_w_q[$];
  wdone_t            exp_wd_q[$];
  rret_t             exp_rd_q[$];

  int checks = 0, errors = 0, w_cnt = 0;
  bit bp = 0;
  logic [1:0] cfg_bresp = 2'b00;
  int cfg_err_beat = -1, cfg_rlast_beat = NT - 1;
  logic [31:0] cfg_rbase = 32'h0;

  task automatic check(input string name, input logic [NATIVE_DW-1:0] act,
                       input logic [NATIVE_DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
  endtask

  function automatic logic rnd_ready();
    return bp ? ($urandom_range(0, 2) == 0) : 1'b1;
  endfunction

  // Write-side slave: AW/W ready (random when bp), B response after the last beat.
  initial begin
    logic w_last_hs, b_hs;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    forever begin
      @(negedge aclk);
      w_last_hs = wvalid && wready && wlast;
      b_hs      = bvalid && bready;
      @(posedge aclk);
      #1;
      awready = rnd_ready();
      wready  = rnd_ready();
      if (b_hs || !aresetn) bvalid = 0;
      if (w_last_hs && aresetn) begin
        bvalid = 1; bresp = cfg_bresp; bid = '0;
      end
    end
  end

  // Read-side slave: beats base+0x11*i, optional early rlast / error beat.
  initial begin
    logic ar_hs, r_hs;
    int rbeat;
    bit ract;
    rbeat = 0; ract = 0;
    arready = 0; rvalid = 0; rdata = 0; rlast = 0; rid = 0; rresp = 0;
    forever begin
      @(negedge aclk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      @(posedge aclk);
      #1;
      arready = rnd_ready();
      if (!aresetn) begin
        ract = 0; rvalid = 0;
      end else begin
        if (ar_hs) begin ract = 1; rbeat = 0; end
        if (r_hs) begin
          if (rlast) ract = 0;
          rbeat++;
        end
        if (!(rvalid && !r_hs)) begin
          if (ract) begin
            rvalid = rnd_ready();
            rdata  = cfg_rbase + 32'h11 * rbeat;
            rlast  = (rbeat == cfg_rlast_beat);
            rresp  = (rbeat == cfg_err_beat) ? 2'b11 : 2'b00;
            rid    = '0;
          end else begin
            rvalid = 0;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction.
  initial begin
    logic aw_st, w_st, ar_st;
    logic [ADDR_W-1:0] aw_pa, ar_pa;
    logic [AXI_DW:0] w_p;
    logic [AXI_DW:0] ew;
    wdone_t ed;
    rret_t er;
    aw_st = 0; w_st = 0; ar_st = 0; aw_pa = 0; ar_pa = 0; w_p = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        aw_st = 0; w_st = 0; ar_st = 0;
        continue;
      end
      if (aw_st) check("aw_stable", {awvalid, awaddr}, {1'b1, aw_pa});
      if (w_st)  check("w_stable", {wvalid, wlast, wdata}, {1'b1, w_p});
      if (ar_st) check("ar_stable", {arvalid, araddr}, {1'b1, ar_pa});
      aw_st = awvalid && !awready; aw_pa = awaddr;
      w_st  = wvalid && !wready;   w_p   = {wlast, wdata};
      ar_st = arvalid && !arready; ar_pa = araddr;
      if (awvalid && awready) begin
        if (exp_aw_q.size() == 0) flag("aw_unexpected");
        else check("aw_fields", {awaddr, awlen, awsize, awburst, awid},
                   {exp_aw_q.pop_front(), 8'd7, 3'd2, 2'b01, 4'd0});
      end
      if (wvalid && wready) begin
        w_cnt++;
        if (exp_w_q.size() == 0) flag("w_unexpected");
        else begin
          ew = exp_w_q.pop_front();
          check("w_beat", {wlast, wstrb, wdata}, {ew[AXI_DW], 4'hF, ew[AXI_DW-1:0]});
        end
      end
      if (arvalid && arready) begin
        if (exp_ar_q.size() == 0) flag("ar_unexpected");
        else check("ar_fields", {araddr, arlen, arsize, arburst, arid},
                   {exp_ar_q.pop_front(), 8'd7, 3'd2, 2'b01, 4'd0});
      end
      if (nat_write_done_o) begin
        $display("write done: err=%0b cycle=%0d", nat_write_err_o, cyc);
        if (exp_wd_q.size() == 0) flag("wr_done_unexpected");
        else begin
          ed = exp_wd_q.pop_front();
          check("wr_err", nat_write_err_o, ed.err);
          if (ed.due >= 0) check("wr_latency", cyc, ed.due);
        end
      end
      if (nat_read_valid_o) begin
        $display("read return: addr=%h err=%0b cycle=%0d", nat_read_addr_o, nat_read_err_o, cyc);
        if (exp_rd_q.size() == 0) flag("rd_unexpected");
        else begin
          er = exp_rd_q.pop_front();
          check("rd_addr", nat_read_addr_o, er.addr);
          check("rd_data", nat_read_data_o & er.mask, er.data & er.mask);
          check("rd_err", nat_read_err_o, er.err);
          if (er.due >= 0) check("rd_latency", cyc, er.due);
        end
      end
    end
  end

  task automatic nat_write(input logic [31:0] addr, input logic [31:0] base, input logic err,
                           input bit timed, output int hs);
    logic [NATIVE_DW-1:0] line;
    for (int i = 0; i < NT; i++) line[i*AXI_DW +: AXI_DW] = base + i;
    @(posedge aclk);
    #1;
    nat_write_valid_i = 1; nat_write_addr_i = addr; nat_write_data_i = line;
    hs = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge aclk);
      if (nat_write_ready_o) begin hs = cyc; break; end
    end
    if (hs < 0) flag("wr_accept_timeout");
    else begin
      exp_aw_q.push_back(addr);
      for (int i = 0; i < NT; i++) exp_w_q.push_back({(i == NT - 1), base + 32'(i)});
      exp_wd_q.push_back('{err, timed ? hs + NT + 3 : -1});
    end
    @(posedge aclk);
    #1;
    nat_write_valid_i = 0; nat_write_addr_i = $urandom; nat_write_data_i = '1;
  endtask

  task automatic nat_read(input logic [31:0] addr, input logic err, input bit timed,
                          output int hs);
    rret_t e;
    @(posedge aclk);
    #1;
    nat_read_valid_i = 1; nat_read_addr_i = addr;
    hs = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge aclk);
      if (nat_read_ready_o) begin hs = cyc; break; end
    end
    if (hs < 0) flag("rd_accept_timeout");
    else begin
      e.addr = addr; e.err = err; e.data = '0; e.mask = '0;
      for (int i = 0; i < NT; i++) begin
        if (i <= cfg_rlast_beat) begin
          e.data[i*AXI_DW +: AXI_DW] = cfg_rbase + 32'h11 * i;
          e.mask[i*AXI_DW +: AXI_DW] = '1;
        end
      end
      e.due = timed ? hs + cfg_rlast_beat + 4 : -1;
      exp_ar_q.push_back(addr);
      exp_rd_q.push_back(e);
    end
    @(posedge aclk);
    #1;
    nat_read_valid_i = 0; nat_read_addr_i = $urandom;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge aclk);
      if (exp_aw_q.size() + exp_w_q.size() + exp_wd_q.size() + exp_ar_q.size() +
          exp_rd_q.size() == 0) begin done = 1; break; end
    end
    if (!done) begin
      flag("drain_timeout");
      exp_aw_q.delete(); exp_w_q.delete(); exp_wd_q.delete();
      exp_ar_q.delete(); exp_rd_q.delete();
    end
  endtask

  function automatic logic [NATIVE_DW-1:0] zero_outputs();
    return {awvalid, awaddr, wvalid, wlast, wdata, bready, arvalid, araddr, rready,
            nat_write_ready_o, nat_read_ready_o, nat_write_done_o, nat_write_err_o,
            nat_read_valid_o, nat_read_err_o, nat_read_addr_o} | nat_read_data_o;
  endfunction

  initial begin
    int w_hs, r_hs, wc0;
    aresetn = 0;
    nat_write_valid_i = 0; nat_write_addr_i = 0; nat_write_data_i = 0;
    nat_read_valid_i = 0; nat_read_addr_i = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_outputs", zero_outputs(), '0);
    check("const_fields", {awburst, awlen, awsize, awid, arburst, arlen, arsize, arid, wstrb},
          {2'b01, 8'd7, 3'd2, 4'd0, 2'b01, 8'd7, 3'd2, 4'd0, 4'hF});
    @(posedge aclk);
    #1 aresetn = 1;
    repeat (2) @(posedge aclk);

    nat_write(32'h100, 32'hA0, 1'b0, 1'b1, w_hs); drain();
    cfg_rbase = 32'h0;
    nat_read(32'h200, 1'b0, 1'b1, r_hs); drain();

    bp = 1;
    nat_write(32'h180, 32'h1000, 1'b0, 1'b0, w_hs);
    cfg_rbase = 32'h55;
    nat_read(32'h280, 1'b0, 1'b0, r_hs);
    drain();
    bp = 0; cfg_rbase = 32'h0;
    repeat (3) @(posedge aclk);

    cfg_bresp = 2'b10;
    nat_write(32'h1C0, 32'h20, 1'b1, 1'b1, w_hs); drain();
    cfg_bresp = 2'b00;

    cfg_err_beat = 3;
    nat_read(32'h240, 1'b1, 1'b1, r_hs); drain();
    cfg_err_beat = -1;

    cfg_rlast_beat = 5;
    nat_read(32'h2C0, 1'b1, 1'b1, r_hs); drain();
    cfg_rlast_beat = NT - 1;

    fork
      nat_write(32'h300, 32'h30, 1'b0, 1'b1, w_hs);
      begin repeat (2) @(negedge aclk); nat_read(32'h300, 1'b0, 1'b1, r_hs); end
    join
    check("hazard_stall", r_hs, w_hs + NT + 3);
    drain();

    fork
      nat_write(32'h300, 32'h40, 1'b0, 1'b1, w_hs);
      begin @(negedge aclk); nat_read(32'h340, 1'b0, 1'b1, r_hs); end
    join
    check("no_hazard_accept", r_hs, w_hs + 1);
    drain();

    fork
      nat_write(32'h400, 32'h70, 1'b0, 1'b1, w_hs);
      nat_read(32'h400, 1'b0, 1'b1, r_hs);
    join
    check("tie_write_wins", r_hs, w_hs + NT + 3);
    drain();

    nat_write(32'h500, 32'h50, 1'b0, 1'b1, w_hs);
    wc0 = w_cnt - 1;
    for (int n = 0; n < 100 && w_cnt < wc0 + 4; n++) @(negedge aclk);
    #2 aresetn = 0;
    #1 check("async_reset_outputs", zero_outputs(), '0);
    exp_aw_q.delete(); exp_w_q.delete(); exp_wd_q.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    repeat (2) @(posedge aclk);
    nat_write(32'h500, 32'h60, 1'b0, 1'b1, w_hs); drain();

    repeat (3) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
